// File: rtl/assoc_buffer_requester.sv
// Initiator for the associative buffer command interface.
// Host requests are queued in a small FIFO and issued to the buffer one at a
// time as a one-cycle key/data/ctrl command. The buffer's combinational
// hit/data result is captured and returned on a valid/ready response port.
// The block also sequences the dump trigger and keeps saturating hit/miss
// statistics.
module assoc_buffer_requester #(
  parameter int KEY_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH_LOG2 = 2,
  // Buffer command encoding; defaults match the buffer's register codes.
  parameter int REG_CTRL_WIDTH  = 2,
  parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = REG_CTRL_WIDTH'(0),
  parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = REG_CTRL_WIDTH'(1),
  parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = REG_CTRL_WIDTH'(2),
  parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC = REG_CTRL_WIDTH'(3)
) (
  input  logic                      clk,
  input  logic                      async_reset,
  // host request port
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [KEY_WIDTH-1:0]      req_key,
  input  logic [DATA_WIDTH-1:0]     req_data,
  // host response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_hit,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [KEY_WIDTH-1:0]      rsp_key,
  // dump request
  input  logic                      dump_req,
  // buffer command side
  output logic [REG_CTRL_WIDTH-1:0] buf_ctrl,
  output logic [KEY_WIDTH-1:0]      buf_key,
  output logic [DATA_WIDTH-1:0]     buf_data,
  output logic                      buf_trigger_read,
  input  logic [DATA_WIDTH-1:0]     buf_data_output,
  input  logic                      buf_data_valid,
  input  logic                      buf_busy,
  // statistics
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP,
    ST_DUMP
  } state_e;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_WRITE  = 2'b01,
    OP_INC    = 2'b10,
    OP_DEC    = 2'b11
  } op_e;

  typedef struct packed {
    logic [1:0]            op;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  // Map a host opcode to the buffer command; a lookup is a plain NOP read.
  function automatic logic [REG_CTRL_WIDTH-1:0] op_to_ctrl(input logic [1:0] op);
    logic [REG_CTRL_WIDTH-1:0] ctrl;
    ctrl = REG_CTRL_NOP;
    case (op_e'(op))
      OP_WRITE: ctrl = REG_CTRL_LD;
      OP_INC:   ctrl = REG_CTRL_INC;
      OP_DEC:   ctrl = REG_CTRL_DEC;
      default:  ctrl = REG_CTRL_NOP;
    endcase
    return ctrl;
  endfunction

  // FIFO storage and bookkeeping
  req_t                       fifo_mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       push, pop;
  req_t                       fifo_head;

  // control and registered outputs
  state_e                     state_q, state_d;
  logic                       dump_pending_q, dump_pending_d;
  logic [REG_CTRL_WIDTH-1:0]  buf_ctrl_q, buf_ctrl_d;
  logic [KEY_WIDTH-1:0]       buf_key_q, buf_key_d;
  logic [DATA_WIDTH-1:0]      buf_data_q, buf_data_d;
  logic                       buf_trigger_read_q, buf_trigger_read_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_hit_q, rsp_hit_d;
  logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic [KEY_WIDTH-1:0]       rsp_key_q, rsp_key_d;
  logic [15:0]                hit_count_q, hit_count_d;
  logic [15:0]                miss_count_q, miss_count_d;

  assign req_ready = (count_q != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  // Next-state, FIFO pointer and output computation for the request sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    state_d            = state_q;
    dump_pending_d     = dump_pending_q | dump_req;
    buf_ctrl_d         = REG_CTRL_NOP;
    buf_key_d          = buf_key_q;
    buf_data_d         = buf_data_q;
    buf_trigger_read_d = 1'b0;
    rsp_valid_d        = rsp_valid_q;
    rsp_hit_d          = rsp_hit_q;
    rsp_data_d         = rsp_data_q;
    rsp_key_d          = rsp_key_q;
    hit_count_d        = hit_count_q;
    miss_count_d       = miss_count_q;
    pop                = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!buf_busy) begin
          if (dump_pending_q) begin
            // A dump request arriving in this very cycle stays pending.
            state_d            = ST_DUMP;
            dump_pending_d     = dump_req;
            buf_trigger_read_d = 1'b1;
          end else if (count_q != '0) begin
            pop        = 1'b1;
            state_d    = ST_ISSUE;
            buf_key_d  = fifo_head.key;
            buf_data_d = fifo_head.data;
            buf_ctrl_d = op_to_ctrl(fifo_head.op);
          end
        end
      end
      ST_ISSUE: begin
        // The buffer result is combinational on buf_key; capture it now,
        // before the command takes effect at this edge.
        rsp_hit_d   = buf_data_valid;
        rsp_data_d  = buf_data_valid ? buf_data_output : '0;
        rsp_key_d   = buf_key_q;
        rsp_valid_d = 1'b1;
        if (buf_data_valid) begin
          hit_count_d = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
        end else begin
          miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_DUMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + FIFO_DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_DEPTH_LOG2'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State, pointer, output and statistics registers.
  always_ff @(posedge clk or posedge async_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (async_reset) begin
      state_q            <= ST_IDLE;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      dump_pending_q     <= 1'b0;
      buf_ctrl_q         <= REG_CTRL_NOP;
      buf_key_q          <= '0;
      buf_data_q         <= '0;
      buf_trigger_read_q <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_hit_q          <= 1'b0;
      rsp_data_q         <= '0;
      rsp_key_q          <= '0;
      hit_count_q        <= '0;
      miss_count_q       <= '0;
    end else begin
      state_q            <= state_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      dump_pending_q     <= dump_pending_d;
      buf_ctrl_q         <= buf_ctrl_d;
      buf_key_q          <= buf_key_d;
      buf_data_q         <= buf_data_d;
      buf_trigger_read_q <= buf_trigger_read_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_hit_q          <= rsp_hit_d;
      rsp_data_q         <= rsp_data_d;
      rsp_key_q          <= rsp_key_d;
      hit_count_q        <= hit_count_d;
      miss_count_q       <= miss_count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an empty count makes
    // its contents unobservable, and leaving it out keeps it a plain RAM.
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{op: req_op, key: req_key, data: req_data};
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_key          = rsp_key_q;
  assign buf_ctrl         = buf_ctrl_q;
  assign buf_key          = buf_key_q;
  assign buf_data         = buf_data_q;
  assign buf_trigger_read = buf_trigger_read_q;
  assign hit_count        = hit_count_q;
  assign miss_count       = miss_count_q;

endmodule
